rrns_decoder_check: RTL and testbench
=====================================

# rrns_decoder_check

Sequential RRNS decoder/checker sitting directly downstream of the 9-channel RRNS encoder, after the channel/error-injection path. It latches nine received residues on a start pulse and reconstructs the 16-bit value from the three non-redundant moduli (64, 63, 65) by mixed-radix conversion. It then re-checks the value against the six redundant residues (67, 71, 73, 79, 83, 89), one per cycle, and reports a mismatch mask, an error flag and a one-cycle done pulse.

## Interface
Parameters:
- none; all moduli and constants come from `rrns_pkg`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: start pulse; sampled only in IDLE.
- `rem_64`, `rem_63` in 6 each: received residues for m1 and m2.
- `rem_65`, `rem_67`, `rem_71`, `rem_73`, `rem_79`, `rem_83`, `rem_89` in 7 each: received residues for m3 to m9.
- `data_out` out 16: reconstructed value, X[15:0].
- `mismatch_mask` out 6: bit i = 1 means the residue for redundant modulus i mismatched. Bit order is {89,83,79,73,71,67}, so bit 0 is modulus 67.
- `range_err` out 1: X > 65535.
- `err` out 1: OR of `mismatch_mask` and `range_err`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when results are valid.

## Operation
- Reset: every output is 0, the state is IDLE, and all internal registers are 0.
- IDLE: when `start`=1, latch all nine residues and go to MRC1.
- MRC1: compute a1 = r64 and a2 = (r63 − (a1 mod 63)) mod 63. The inverse of 64 mod 63 is 1.
- MRC2: compute a3 = (((r65 − a1)·64 − a2)·32) mod 65.
  - 64 is the inverse of 64 mod 65.
  - 32 is the inverse of 63 mod 65.
  - All subtractions are performed modulo the target modulus, never as a negative wrap.
- RECON: compute X = a1 + 64·a2 + 4032·a3 as an 18-bit value; the maximum is 262079.
- CHECK: a 3-bit index k runs 0..5. Each cycle compute X mod m(4+k), compare it with the latched residue, and write `mismatch_mask[k]`. After k=5, go to DONE.
- DONE: register `data_out`, `range_err` and `err`, and assert `done`=1 for this cycle only. Next state is IDLE.
- `start` outside IDLE is ignored; this includes DONE. No queueing.
- Residue inputs are don't-care except in the IDLE cycle where `start`=1.
- Out-of-range input residues (e.g. `rem_63`=63) are reduced modulo their modulus at latch time.
- `data_out`, `mismatch_mask`, `range_err` and `err` hold their values until the next DONE or reset.
- `mismatch_mask` is cleared when a new operation is accepted.

## Timing
- Cycle numbering: edge 0 is the edge that samples `start`=1 in IDLE. `busy` is 1 from edge 0.
- Edge 1 registers a2, edge 2 registers a3, and edge 3 registers X.
- Edges 4..9 perform checks k=0..5; edge 9 also enters DONE.
- `done`, `err`, `range_err` and `data_out` are valid from edge 9. `done` is low again and the block is back in IDLE at edge 10.
- Latency is 9 cycles from start to done.
- Throughput is one operation per 11 cycles: the next `start` is accepted at edge 11 at the earliest, since the block is in IDLE only from edge 10.
- `rst` asserted in any state forces the state to IDLE and all outputs to 0 at the next edge. A `done` in flight is lost.
- `rst` has priority over `start`.

## Configuration
- `RRNS_DEC_RANGE_CHECK_EN` defined:
  - `range_err` = (X > 65535).
  - `err` includes `range_err`.
- `RRNS_DEC_RANGE_CHECK_EN` undefined:
  - `range_err` is tied to 0.
  - `err` = |`mismatch_mask`.
- In both cases `data_out` = X[15:0].

## Structure
- `rrns_pkg` holds:
  - the moduli 64, 63, 65, 67, 71, 73, 79, 83, 89;
  - the inverse constants 1, 64, 32;
  - the weights 64 and 4032;
  - residue widths;
  - the state enum {IDLE, MRC1, MRC2, RECON, CHECK, DONE}.
- One sub-module, `rrns_mod_sel`: combinational X[17:0] mod m(4+k) selected by k[2:0]. Output width is 7.

## Test plan
- Reset, then `start` with all residues 0 → `done` at edge 9; `data_out`=0, `mismatch_mask`=0, `err`=0, `busy` high during edges 0..9.
- Residues of 65535 (63, 15, 15, 9, 2, 54, 44, 48, 31) → intermediate values a2=15, a3=16, X=65535. Outputs: `data_out`=65535, `err`=0.
- Same residues as above but `rem_71`=3 → `mismatch_mask`=6'b000010, `err`=1, `data_out`=65535.
- `rem_64`=0, `rem_63`=0, `rem_65`=1, redundant residues = 133056 mod m → X=133056.
  - With the macro: `range_err`=1, `err`=1, `data_out`=1984.
  - Without the macro: `range_err`=0, `err`=0, `data_out`=1984.
- Accepted `start` for 1000, then `start` with other data at edges 3 and 9 → both ignored; `data_out`=1000 with a single `done` pulse; a `start` at edge 11 is accepted.
- `rst` at edge 6 during CHECK → outputs 0 at edge 7, no `done`; a new `start` afterwards completes normally.

Source files
------------

// File: rtl/rrns_pkg.sv
// +----------------------------------------------------------------------------+
// | rrns_pkg                                                                   |
// | Moduli, MRC inverses/weights, residue widths and FSM states for the       |
// | RRNS decoder/checker.                                                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package rrns_pkg;

    localparam int unsigned C_M64 = 64;
    localparam int unsigned C_M63 = 63;
    localparam int unsigned C_M65 = 65;
    localparam int unsigned C_M67 = 67;
    localparam int unsigned C_M71 = 71;
    localparam int unsigned C_M73 = 73;
    localparam int unsigned C_M79 = 79;
    localparam int unsigned C_M83 = 83;
    localparam int unsigned C_M89 = 89;

    localparam int unsigned C_INV64_M63 = 1;
    localparam int unsigned C_INV64_M65 = 64;
    localparam int unsigned C_INV63_M65 = 32;

    localparam int unsigned C_WGT2 = 64;
    localparam int unsigned C_WGT3 = 4032;

    localparam int unsigned C_RW_LO = 6;
    localparam int unsigned C_RW_HI = 7;
    localparam int unsigned C_XW    = 18;
    localparam int unsigned C_DW    = 16;
    localparam int unsigned C_NRED  = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MRC1  = 3'd1,
        MRC2  = 3'd2,
        RECON = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_e;

    // A 7-bit residue is always below 2*m for every 7-bit modulus used here.
    function automatic logic [6:0] reduce7(input logic [6:0] v, input int unsigned m);
        return (v >= 7'(m)) ? v - 7'(m) : v;
    endfunction

    // (a - b) mod m for a, b already reduced; never wraps negative.
    function automatic logic [6:0] sub_mod(input logic [6:0] a, input logic [6:0] b,
                                           input int unsigned m);
        return (a >= b) ? a - b : 7'(8'(a) + 8'(m) - 8'(b));
    endfunction

endpackage

`default_nettype wire

// File: rtl/rrns_decoder_check_if.sv
// +----------------------------------------------------------------------------+
// | rrns_decoder_check_if                                                      |
// | Residue inputs, start strobe and result outputs of the RRNS decoder.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface rrns_decoder_check_if;
    import rrns_pkg::*;

    logic                 start;
    logic [C_RW_LO-1:0]   rem_64;
    logic [C_RW_LO-1:0]   rem_63;
    logic [C_RW_HI-1:0]   rem_65;
    logic [C_RW_HI-1:0]   rem_67;
    logic [C_RW_HI-1:0]   rem_71;
    logic [C_RW_HI-1:0]   rem_73;
    logic [C_RW_HI-1:0]   rem_79;
    logic [C_RW_HI-1:0]   rem_83;
    logic [C_RW_HI-1:0]   rem_89;
    logic [C_DW-1:0]      data_out;
    logic [C_NRED-1:0]    mismatch_mask;
    logic                 range_err;
    logic                 err;
    logic                 busy;
    logic                 done;

    modport master (
        output start, rem_64, rem_63, rem_65, rem_67, rem_71, rem_73, rem_79, rem_83, rem_89,
        input  data_out, mismatch_mask, range_err, err, busy, done
    );

    modport slave (
        input  start, rem_64, rem_63, rem_65, rem_67, rem_71, rem_73, rem_79, rem_83, rem_89,
        output data_out, mismatch_mask, range_err, err, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/rrns_mod_sel.sv
// +----------------------------------------------------------------------------+
// | rrns_mod_sel                                                               |
// | Combinational X mod m(4+k) for the six redundant moduli, selected by k.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rrns_mod_sel
    import rrns_pkg::*;
(
    input  logic [C_XW-1:0]    i_x,
    input  logic [2:0]         i_k,
    output logic [C_RW_HI-1:0] o_rem
);

    always_comb begin
        o_rem = '0;
        case (i_k)
            3'd0:    o_rem = 7'(i_x % 18'(C_M67));
            3'd1:    o_rem = 7'(i_x % 18'(C_M71));
            3'd2:    o_rem = 7'(i_x % 18'(C_M73));
            3'd3:    o_rem = 7'(i_x % 18'(C_M79));
            3'd4:    o_rem = 7'(i_x % 18'(C_M83));
            3'd5:    o_rem = 7'(i_x % 18'(C_M89));
            default: o_rem = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rrns_decoder_check.sv
// +----------------------------------------------------------------------------+
// | rrns_decoder_check                                                         |
// | Sequential RRNS decoder: MRC over (64,63,65), then per-cycle check of the  |
// | six redundant residues. Optional range check: RRNS_DEC_RANGE_CHECK_EN.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rrns_decoder_check
    import rrns_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    rrns_decoder_check_if.slave bus
);

    state_e                      state_q, state_d;
    logic [2:0]                  k_q, k_d;
    logic [C_RW_LO-1:0]          r64_q, r64_d;
    logic [C_RW_LO-1:0]          r63_q, r63_d;
    logic [C_RW_HI-1:0]          r65_q, r65_d;
    logic [C_NRED-1:0][C_RW_HI-1:0] red_q, red_d;
    logic [C_RW_LO-1:0]          a2_q, a2_d;
    logic [C_RW_HI-1:0]          a3_q, a3_d;
    logic [C_XW-1:0]             x_q, x_d;
    logic [C_NRED-1:0]           mask_q, mask_d;
    logic [C_DW-1:0]             data_q, data_d;
    logic                        rerr_q, rerr_d;
    logic                        err_q, err_d;

    logic [C_RW_LO-1:0]          w_a1_m63;
    logic [C_RW_LO-1:0]          w_a2;
    logic [C_RW_HI-1:0]          w_t1, w_t2, w_t3, w_a3;
    logic [C_XW-1:0]             w_x;
    logic [C_RW_HI-1:0]          w_rem;
    logic [C_NRED-1:0]           w_mask_upd;
    logic                        w_range;

    rrns_mod_sel u_mod_sel (
        .i_x   (x_q),
        .i_k   (k_q),
        .o_rem (w_rem)
    );

    // Mixed-radix digits; a1 is r64 itself.
    always_comb begin
        w_a1_m63 = (r64_q == 6'(C_M63)) ? '0 : r64_q;
        w_a2     = 6'((13'(sub_mod({1'b0, r63_q}, {1'b0, w_a1_m63}, C_M63))
                       * 13'(C_INV64_M63)) % 13'(C_M63));
        w_t1     = sub_mod(r65_q, {1'b0, r64_q}, C_M65);
        w_t2     = 7'((13'(w_t1) * 13'(C_INV64_M65)) % 13'(C_M65));
        w_t3     = sub_mod(w_t2, {1'b0, a2_q}, C_M65);
        w_a3     = 7'((13'(w_t3) * 13'(C_INV63_M65)) % 13'(C_M65));
        w_x      = 18'(r64_q) + 18'(a2_q) * 18'(C_WGT2) + 18'(a3_q) * 18'(C_WGT3);
    end

    always_comb begin
        w_mask_upd      = mask_q;
        w_mask_upd[k_q] = (w_rem != red_q[k_q]);
    end

`ifdef RRNS_DEC_RANGE_CHECK_EN
    assign w_range = (x_q > 18'd65535);
`else
    assign w_range = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = MRC1;
            MRC1:    state_d = MRC2;
            MRC2:    state_d = RECON;
            RECON:   state_d = CHECK;
            CHECK:   if (k_q == 3'(C_NRED - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        k_d    = k_q;
        r64_d  = r64_q;
        r63_d  = r63_q;
        r65_d  = r65_q;
        red_d  = red_q;
        a2_d   = a2_q;
        a3_d   = a3_q;
        x_d    = x_q;
        mask_d = mask_q;
        data_d = data_q;
        rerr_d = rerr_q;
        err_d  = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    r64_d    = bus.rem_64;
                    r63_d    = (bus.rem_63 == 6'(C_M63)) ? '0 : bus.rem_63;
                    r65_d    = reduce7(bus.rem_65, C_M65);
                    red_d[0] = reduce7(bus.rem_67, C_M67);
                    red_d[1] = reduce7(bus.rem_71, C_M71);
                    red_d[2] = reduce7(bus.rem_73, C_M73);
                    red_d[3] = reduce7(bus.rem_79, C_M79);
                    red_d[4] = reduce7(bus.rem_83, C_M83);
                    red_d[5] = reduce7(bus.rem_89, C_M89);
                    mask_d   = '0;
                    k_d      = '0;
                end
            end
            MRC1:  a2_d = w_a2;
            MRC2:  a3_d = w_a3;
            RECON: begin
                x_d = w_x;
                k_d = '0;
            end
            CHECK: begin
                mask_d = w_mask_upd;
                k_d    = k_q + 3'd1;
                // Results are registered on the last check so they coincide with done.
                if (k_q == 3'(C_NRED - 1)) begin
                    data_d = x_q[C_DW-1:0];
                    rerr_d = w_range;
                    err_d  = (|w_mask_upd) | w_range;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q    <= '0;
            r64_q  <= '0;
            r63_q  <= '0;
            r65_q  <= '0;
            red_q  <= '0;
            a2_q   <= '0;
            a3_q   <= '0;
            x_q    <= '0;
            mask_q <= '0;
            data_q <= '0;
            rerr_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            k_q    <= k_d;
            r64_q  <= r64_d;
            r63_q  <= r63_d;
            r65_q  <= r65_d;
            red_q  <= red_d;
            a2_q   <= a2_d;
            a3_q   <= a3_d;
            x_q    <= x_d;
            mask_q <= mask_d;
            data_q <= data_d;
            rerr_q <= rerr_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE);
    end

    assign bus.data_out      = data_q;
    assign bus.mismatch_mask = mask_q;
    assign bus.range_err     = rerr_q;
    assign bus.err           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rrns_decoder_check.sv
// +----------------------------------------------------------------------------+
// | tb_rrns_decoder_check                                                      |
// | Scoreboard bench: expected results come from a CRT search model.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rrns_decoder_check;

    typedef struct {
        logic [15:0] data;
        logic [5:0]  mask;
        logic        rerr;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    int   stim[9];
    int   mods[9] = '{64, 63, 65, 67, 71, 73, 79, 83, 89};

    always #5 clk = ~clk;

    rrns_decoder_check_if bus ();

    rrns_decoder_check dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_x(input int x);
        for (int i = 0; i < 9; i++) stim[i] = x % mods[i];
    endtask

    task automatic apply_rems();
        bus.rem_64 = 6'(stim[0]);
        bus.rem_63 = 6'(stim[1]);
        bus.rem_65 = 7'(stim[2]);
        bus.rem_67 = 7'(stim[3]);
        bus.rem_71 = 7'(stim[4]);
        bus.rem_73 = 7'(stim[5]);
        bus.rem_79 = 7'(stim[6]);
        bus.rem_83 = 7'(stim[7]);
        bus.rem_89 = 7'(stim[8]);
    endtask

    // Drives start for one edge (edge 0); returns at the negedge after it.
    task automatic drive_start(input bit push);
        exp_t ex;
        int   x;
        x = -1;
        apply_rems();
        bus.start = 1'b1;
        if (push) begin
            for (int j = 0; j < 4095; j++) begin
                int c;
                c = (stim[0] % 64) + 64 * j;
                if (x < 0 && (c % 63) == (stim[1] % 63) && (c % 65) == (stim[2] % 65)) x = c;
            end
            ex.mask = '0;
            for (int i = 0; i < 6; i++)
                ex.mask[i] = ((x % mods[3+i]) != (stim[3+i] % mods[3+i]));
`ifdef RRNS_DEC_RANGE_CHECK_EN
            ex.rerr = (x > 65535);
`else
            ex.rerr = 1'b0;
`endif
            ex.err  = (|ex.mask) | ex.rerr;
            ex.data = 16'(x);
            sb.push_back(ex);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output bit busy_ok);
        edges   = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        set_x(0);
        apply_rems();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.data_out, bus.mismatch_mask, bus.range_err, bus.err} !== 24'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got data=%0d mask=%b rerr=%b err=%b, want all 0",
                     bus.data_out, bus.mismatch_mask, bus.range_err, bus.err);
        end
        n_cmp++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_status: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        exp_t ex;
        int   e;
        bit   bok;
        set_x(0);
        drive_start(1'b1);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL zero_busy_edge0: got busy=%b, want 1", bus.busy);
        end
        wait_done(e, bok);
        n_cmp++;
        if (e !== 9 || !bok) begin
            n_err++;
            $display("FAIL zero_latency: got done at edge %0d busy_ok=%b, want edge 9 busy_ok=1", e, bok);
        end
        ex = sb.pop_front();
        n_cmp++;
        if ({bus.data_out, bus.mismatch_mask, bus.err} !== {ex.data, ex.mask, ex.err}
            || bus.data_out !== 16'd0) begin
            n_err++;
            $display("FAIL zero_result: got data=%0d mask=%b err=%b, want data=0 mask=0 err=0",
                     bus.data_out, bus.mismatch_mask, bus.err);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_err++;
            $display("FAIL zero_idle_edge10: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_pattern(input string name, input int x, input int idx_a, input int val_a,
                                input int idx_b, input int val_b, input logic [15:0] want_data,
                                input logic [5:0] want_mask);
        exp_t ex;
        int   e;
        bit   bok;
        set_x(x);
        if (idx_a >= 0) stim[idx_a] = val_a;
        if (idx_b >= 0) stim[idx_b] = val_b;
        drive_start(1'b1);
        wait_done(e, bok);
        n_cmp++;
        if (e !== 9) begin
            n_err++;
            $display("FAIL %s_latency: got done at edge %0d, want 9", name, e);
        end
        ex = sb.pop_front();
        n_cmp++;
        if ({bus.data_out, bus.mismatch_mask, bus.range_err, bus.err}
            !== {ex.data, ex.mask, ex.rerr, ex.err}) begin
            n_err++;
            $display("FAIL %s_result: got data=%0d mask=%b rerr=%b err=%b, want data=%0d mask=%b rerr=%b err=%b",
                     name, bus.data_out, bus.mismatch_mask, bus.range_err, bus.err,
                     ex.data, ex.mask, ex.rerr, ex.err);
        end
        n_cmp++;
        if (bus.data_out !== want_data || bus.mismatch_mask !== want_mask) begin
            n_err++;
            $display("FAIL %s_known: got data=%0d mask=%b, want data=%0d mask=%b",
                     name, bus.data_out, bus.mismatch_mask, want_data, want_mask);
        end
        @(negedge clk);
    endtask

    task automatic test_range();
        exp_t ex;
        int   e;
        bit   bok;
        logic want_rerr;
`ifdef RRNS_DEC_RANGE_CHECK_EN
        want_rerr = 1'b1;
`else
        want_rerr = 1'b0;
`endif
        set_x(133056);
        drive_start(1'b1);
        wait_done(e, bok);
        ex = sb.pop_front();
        n_cmp++;
        if ({bus.data_out, bus.mismatch_mask, bus.range_err, bus.err}
            !== {ex.data, ex.mask, ex.rerr, ex.err}) begin
            n_err++;
            $display("FAIL range_result: got data=%0d mask=%b rerr=%b err=%b, want data=%0d mask=%b rerr=%b err=%b",
                     bus.data_out, bus.mismatch_mask, bus.range_err, bus.err,
                     ex.data, ex.mask, ex.rerr, ex.err);
        end
        n_cmp++;
        if (e !== 9 || bus.data_out !== 16'd1984 || bus.range_err !== want_rerr
            || bus.err !== want_rerr) begin
            n_err++;
            $display("FAIL range_known: got edge=%0d data=%0d rerr=%b err=%b, want edge=9 data=1984 rerr=%b err=%b",
                     e, bus.data_out, bus.range_err, bus.err, want_rerr, want_rerr);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        exp_t        ex;
        int          e;
        bit          bok;
        int          pulses;
        logic [15:0] got;
        logic [5:0]  got_mask;
        logic        got_err;
        pulses   = 0;
        got      = '0;
        got_mask = '0;
        got_err  = 1'b0;
        set_x(1000);
        drive_start(1'b1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                got      = bus.data_out;
                got_mask = bus.mismatch_mask;
                got_err  = bus.err;
            end
            if (i == 2 || i == 8) begin
                set_x(30000 + i);
                apply_rems();
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        ex = sb.pop_front();
        n_cmp++;
        if (pulses !== 1 || got !== 16'd1000) begin
            n_err++;
            $display("FAIL ignore_start: got %0d done pulses data=%0d, want 1 pulse data=1000", pulses, got);
        end
        n_cmp++;
        if ({got, got_mask, got_err} !== {ex.data, ex.mask, ex.err}) begin
            n_err++;
            $display("FAIL ignore_result: got data=%0d mask=%b err=%b, want data=%0d mask=%b err=%b",
                     got, got_mask, got_err, ex.data, ex.mask, ex.err);
        end
        set_x(2000);
        drive_start(1'b1);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL accept_edge11: got busy=%b, want 1", bus.busy);
        end
        wait_done(e, bok);
        ex = sb.pop_front();
        n_cmp++;
        if (e !== 9 || bus.data_out !== ex.data || bus.err !== ex.err) begin
            n_err++;
            $display("FAIL accept_result: got edge=%0d data=%0d err=%b, want edge=9 data=%0d err=%b",
                     e, bus.data_out, bus.err, ex.data, ex.err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midway();
        exp_t ex;
        int   e;
        bit   bok;
        int   pulses;
        pulses = 0;
        set_x(777);
        drive_start(1'b1);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        void'(sb.pop_back());
        n_cmp++;
        if ({bus.data_out, bus.mismatch_mask, bus.range_err, bus.err, bus.busy, bus.done} !== 26'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got data=%0d mask=%b rerr=%b err=%b busy=%b done=%b, want all 0",
                     bus.data_out, bus.mismatch_mask, bus.range_err, bus.err, bus.busy, bus.done);
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL midreset_no_done: got %0d done pulses, want 0", pulses);
        end
        set_x(4321);
        drive_start(1'b1);
        wait_done(e, bok);
        ex = sb.pop_front();
        n_cmp++;
        if (e !== 9 || {bus.data_out, bus.mismatch_mask, bus.err} !== {ex.data, ex.mask, ex.err}) begin
            n_err++;
            $display("FAIL midreset_recover: got edge=%0d data=%0d mask=%b err=%b, want edge=9 data=%0d mask=%b err=%b",
                     e, bus.data_out, bus.mismatch_mask, bus.err, ex.data, ex.mask, ex.err);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_pattern("max", 65535, -1, 0, -1, 0, 16'd65535, 6'b000000);
        test_pattern("bad71", 65535, 4, 3, -1, 0, 16'd65535, 6'b000010);
        test_pattern("bad67_89", 12345, 3, (12345 % 67 + 1) % 67, 8, (12345 % 89 + 5) % 89,
                     16'd12345, 6'b100001);
        test_pattern("unreduced", 0, 1, 63, 2, 65, 16'd0, 6'b000000);
        test_range();
        test_ignore_start();
        test_reset_midway();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
